mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the core's single AXI4 memory master (read, write and response channels; 22-bit byte address) between two requesters.
- Port 0 is the exec load/store path; port 1 is the instruction-fetch/loader path.
- Each requester issues a one-cycle request pulse and receives a one-cycle done pulse carrying read data.
- The arbiter grants one transaction at a time, drives the AXI handshakes, derives byte strobes and extracts byte-lane data.

Parameters:
- ADDR_W, 22, byte-address width on requester and AXI sides.
- RR, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 first.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-port one-cycle request pulse (bit i = port i).
- req_we  in  2  per-port 1 = store, 0 = load.
- req_size  in  2x3  per-port AXI size; 3'b000 = byte, 3'b010 = word.
- req_addr  in  2xADDR_W  per-port byte address.
- req_wdata  in  2x32  per-port store data (byte stores use bits [7:0]).
- resp_done  out  2  per-port one-cycle completion pulse.
- resp_err  out  2  per-port error, valid with resp_done.
- resp_rdata  out  32  load data, valid with resp_done.
- araddr  out  ADDR_W  AXI read address.
- arsize  out  3  AXI read size.
- arvalid  out  1  AXI read-address valid.
- arready  in  1  AXI read-address ready.
- rdata  in  32  AXI read data.
- rresp  in  2  AXI read response.
- rvalid  in  1  AXI read-data valid.
- rready  out  1  AXI read-data ready.
- awaddr  out  ADDR_W  AXI write address.
- awsize  out  3  AXI write size.
- awvalid  out  1  AXI write-address valid.
- awready  in  1  AXI write-address ready.
- wdata  out  32  AXI write data.
- wstrb  out  4  AXI write byte strobes.
- wvalid  out  1  AXI write-data valid.
- wready  in  1  AXI write-data ready.
- bresp  in  2  AXI write response.
- bvalid  in  1  AXI write-response valid.
- bready  out  1  AXI write-response ready.
- Fixed fields (burst=INCR, len=0, cache=4'b0011, prot=0, lock=0, wlast=1) are tied off at the top level and are not ports.

Behaviour:
- Reset (rst=1 at edge): state=IDLE; pending[1:0]=0; last_grant=1 (port 0 wins the first tie); all valid/ready/done/err outputs 0; addresses, data and wstrb 0. Reset mid-transaction abandons it silently: no done pulse, pending cleared. The AXI slave shares the reset.
- Request capture: req_valid[i] with pending[i]=0 latches we/size/addr/wdata into slot i and sets pending[i] at that edge.
  - req_valid[i] while pending[i]=1 is ignored (protocol violation; no corruption of the latched slot).
  - pending[i] clears at the edge that raises resp_done[i], so a req_valid[i] in the same cycle as resp_done[i]=1 is accepted.
- State machine IDLE / READ / WRITE / RESP:
  - IDLE, any pending: select grant g.
    - RR=1 with both pending: g = ~last_grant.
    - RR=0 with both pending: g = 0.
    - Otherwise g = the single pending port.
    - Set last_grant=g.
    - Load: araddr, arsize from slot; arvalid=1; rready=1; go READ.
    - Store: awaddr, awsize from slot; wdata; wstrb; awvalid=wvalid=bready=1; go WRITE.
  - Grant occurs at the edge after capture at the earliest, so arvalid/awvalid first appear 1 cycle after the req_valid cycle.
  - READ:
    - arvalid drops at the edge after arvalid&&arready.
    - On rvalid&&rready: rready=0; latch rresp_rdata; err=(rresp!=0); go RESP.
    - rvalid in the same cycle as the ar handshake is legal.
  - WRITE:
    - awvalid and wvalid each drop independently on their own handshake, in either order or together.
    - On bvalid&&bready: bready=0; err=(bresp!=0); go RESP.
  - RESP, one cycle:
    - resp_done[g]=1, resp_err[g]=err; resp_rdata holds the result; clear pending[g]; go IDLE.
    - The next grant is made in IDLE, so back-to-back transactions are separated by at least one IDLE cycle.
- Data rules:
  - Word store: wstrb=4'hf, wdata=req_wdata.
  - Byte store: wstrb=4'b0001<<addr[1:0]; wdata=replicate(req_wdata[7:0], 4).
  - Word load: resp_rdata=rdata.
  - Byte load: resp_rdata={24'h0, rdata[8*addr[1:0] +: 8]} (zero-extended).
  - Word accesses drive addr unchanged; misalignment is not checked.
  - Unsupported size (not 000/010) is passed through as word behaviour.
- resp_rdata is 0 for stores. resp_done/resp_err are 0 in all non-RESP cycles.

Test Plan:
- Port 0 load addr 0x000100, size 010; slave arready at once, rvalid 2 cycles later with 0xDEADBEEF -> arvalid 1 cycle after req; resp_done[0] 1 cycle after r handshake with resp_rdata=0xDEADBEEF, resp_err=0.
- Port 1 byte store addr 0x000203, wdata 0x000000A5 -> awaddr=0x000203, wstrb=4'b1000, wdata=0xA5A5A5A5; wready 3 cycles before awready accepted; one resp_done[1] after bvalid.
- Both ports pulse in the same cycle, RR=1, repeated 4 times -> grants 0,1,0,1; with RR=0 -> port 0 always first, port 1 served immediately after.
- Byte load addr 0x00000A, rdata 0x11223344 -> resp_rdata=0x00000022; rresp=2'b10 on another load -> resp_err=1 with done.
- rst asserted while WRITE waits on bvalid -> all AXI valids/readies 0 next cycle, no resp_done; new port 0 request after reset is served normally.
- req_valid[0] in the resp_done[0] cycle -> accepted and served; req_valid[0] while pending -> ignored, original address served.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one AXI4 memory master between two requesters:
//   port 0 = exec load/store path, port 1 = instruction-fetch/loader path.
//   Requesters issue one-cycle request pulses; each request is latched into a
//   per-port slot and served one at a time. A one-cycle done pulse returns the
//   load data (byte loads are lane-extracted and zero-extended) and the error.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/we/size/addr/wdata   per-port request (index = port)
//   resp_done/resp_err        per-port completion pulse and error
//   resp_rdata                load result, valid with resp_done
//   ar*/r*                    AXI read address / read data channels
//   aw*/w*/b*                 AXI write address / write data / response channels
//
// FSM states
//   state   | meaning
//   S_IDLE  | no transaction in flight; grant a pending slot if any
//   S_READ  | AR issued, waiting for AR handshake and R beat
//   S_WRITE | AW and W issued, waiting for both handshakes and B beat
//   S_RESP  | one-cycle done pulse to the granted port
module mem_arbiter #(
    parameter int ADDR_W = 22,
    parameter bit RR     = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_we,
    input  logic [1:0][2:0]        req_size,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][31:0]       req_wdata,
    output logic [1:0]             resp_done,
    output logic [1:0]             resp_err,
    output logic [31:0]            resp_rdata,
    output logic [ADDR_W-1:0]      araddr,
    output logic [2:0]             arsize,
    output logic                   arvalid,
    input  logic                   arready,
    input  logic [31:0]            rdata,
    input  logic [1:0]             rresp,
    input  logic                   rvalid,
    output logic                   rready,
    output logic [ADDR_W-1:0]      awaddr,
    output logic [2:0]             awsize,
    output logic                   awvalid,
    input  logic                   awready,
    output logic [31:0]            wdata,
    output logic [3:0]             wstrb,
    output logic                   wvalid,
    input  logic                   wready,
    input  logic [1:0]             bresp,
    input  logic                   bvalid,
    output logic                   bready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // request slots
    logic [1:0]             slot_we;
    logic [1:0][2:0]        slot_size;
    logic [1:0][ADDR_W-1:0] slot_addr;
    logic [1:0][31:0]       slot_wdata;
    logic [1:0]             pending_q, pending_d, pending_clr, accept;

    // current transaction context
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic        cur_byte_q, cur_byte_d;
    logic [1:0]  cur_off_q, cur_off_d;
    logic        err_q, err_d;
    logic [31:0] result_q, result_d;
    logic [7:0]  rd_byte;
    logic        g_sel;
    logic        sel_byte;

    // next values of registered AXI outputs
    logic [ADDR_W-1:0] araddr_d, awaddr_d;
    logic [2:0]        arsize_d, awsize_d;
    logic              arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;
    logic [31:0]       wdata_d;
    logic [3:0]        wstrb_d;

    // a slot only accepts a new request once its previous one has completed
    assign accept = req_valid & ~pending_q;

    always_comb begin
        rd_byte = rdata[7:0];
        case (cur_off_q)
            2'd0: rd_byte = rdata[7:0];
            2'd1: rd_byte = rdata[15:8];
            2'd2: rd_byte = rdata[23:16];
            2'd3: rd_byte = rdata[31:24];
            default: rd_byte = rdata[7:0];
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cur_byte_d   = cur_byte_q;
        cur_off_d    = cur_off_q;
        err_d        = err_q;
        result_d     = result_q;
        araddr_d     = araddr;
        arsize_d     = arsize;
        arvalid_d    = arvalid;
        rready_d     = rready;
        awaddr_d     = awaddr;
        awsize_d     = awsize;
        awvalid_d    = awvalid;
        wdata_d      = wdata;
        wstrb_d      = wstrb;
        wvalid_d     = wvalid;
        bready_d     = bready;
        pending_clr  = 2'b00;
        g_sel        = 1'b0;
        sel_byte     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    if (&pending_q)
                        g_sel = RR ? ~last_grant_q : 1'b0;
                    else
                        g_sel = pending_q[1];
                    // anything other than a byte size behaves as a word access
                    sel_byte     = (slot_size[g_sel] == 3'b000);
                    grant_d      = g_sel;
                    last_grant_d = g_sel;
                    cur_byte_d   = sel_byte;
                    cur_off_d    = slot_addr[g_sel][1:0];
                    if (slot_we[g_sel]) begin
                        awaddr_d  = slot_addr[g_sel];
                        awsize_d  = slot_size[g_sel];
                        wdata_d   = sel_byte ? {4{slot_wdata[g_sel][7:0]}} : slot_wdata[g_sel];
                        wstrb_d   = sel_byte ? (4'b0001 << slot_addr[g_sel][1:0]) : 4'hf;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                        state_d   = S_WRITE;
                    end else begin
                        araddr_d  = slot_addr[g_sel];
                        arsize_d  = slot_size[g_sel];
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        state_d   = S_READ;
                    end
                end
            end
            S_READ: begin
                if (arvalid && arready)
                    arvalid_d = 1'b0;
                if (rvalid && rready) begin
                    arvalid_d   = 1'b0;
                    rready_d    = 1'b0;
                    err_d       = (rresp != 2'b00);
                    result_d    = cur_byte_q ? {24'h0, rd_byte} : rdata;
                    // freeing the slot now lets a request in the done cycle be taken
                    pending_clr = grant_q ? 2'b10 : 2'b01;
                    state_d     = S_RESP;
                end
            end
            S_WRITE: begin
                if (awvalid && awready)
                    awvalid_d = 1'b0;
                if (wvalid && wready)
                    wvalid_d = 1'b0;
                if (bvalid && bready) begin
                    awvalid_d   = 1'b0;
                    wvalid_d    = 1'b0;
                    bready_d    = 1'b0;
                    err_d       = (bresp != 2'b00);
                    result_d    = 32'h0;
                    pending_clr = grant_q ? 2'b10 : 2'b01;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        pending_d = (pending_q & ~pending_clr) | accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pending_q    <= 2'b00;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            cur_byte_q   <= 1'b0;
            cur_off_q    <= 2'd0;
            err_q        <= 1'b0;
            result_q     <= 32'h0;
            araddr       <= '0;
            arsize       <= 3'd0;
            arvalid      <= 1'b0;
            rready       <= 1'b0;
            awaddr       <= '0;
            awsize       <= 3'd0;
            awvalid      <= 1'b0;
            wdata        <= 32'h0;
            wstrb        <= 4'h0;
            wvalid       <= 1'b0;
            bready       <= 1'b0;
            slot_we      <= 2'b00;
            slot_size    <= '0;
            slot_addr    <= '0;
            slot_wdata   <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cur_byte_q   <= cur_byte_d;
            cur_off_q    <= cur_off_d;
            err_q        <= err_d;
            result_q     <= result_d;
            araddr       <= araddr_d;
            arsize       <= arsize_d;
            arvalid      <= arvalid_d;
            rready       <= rready_d;
            awaddr       <= awaddr_d;
            awsize       <= awsize_d;
            awvalid      <= awvalid_d;
            wdata        <= wdata_d;
            wstrb        <= wstrb_d;
            wvalid       <= wvalid_d;
            bready       <= bready_d;
            for (int i = 0; i < 2; i++) begin
                if (accept[i]) begin
                    slot_we[i]    <= req_we[i];
                    slot_size[i]  <= req_size[i];
                    slot_addr[i]  <= req_addr[i];
                    slot_wdata[i] <= req_wdata[i];
                end
            end
        end
    end

    assign resp_done  = (state_q == S_RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign resp_err   = (state_q == S_RESP && err_q) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign resp_rdata = result_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter. u0 is the round-robin build, u1 the
//   fixed-priority build; both see the same requests and slave responses,
//   so they stay in lock-step except where grant order differs.
//   Inputs are driven and outputs sampled on the falling edge.
module tb_mem_arbiter;

    localparam int ADDR_W = 22;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [1:0]             req_valid;
    logic [1:0]             req_we;
    logic [1:0][2:0]        req_size;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][31:0]       req_wdata;
    logic                   arready, rvalid, awready, wready, bvalid;
    logic [31:0]            rdata;
    logic [1:0]             rresp, bresp;

    logic [1:0]        resp_done, resp_err;
    logic [31:0]       resp_rdata;
    logic [ADDR_W-1:0] araddr, awaddr;
    logic [2:0]        arsize, awsize;
    logic              arvalid, rready, awvalid, wvalid, bready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;

    logic [1:0]        resp_done_b, resp_err_b;
    logic [31:0]       resp_rdata_b;
    logic [ADDR_W-1:0] araddr_b, awaddr_b;
    logic [2:0]        arsize_b, awsize_b;
    logic              arvalid_b, rready_b, awvalid_b, wvalid_b, bready_b;
    logic [31:0]       wdata_b;
    logic [3:0]        wstrb_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .RR(1'b1)) u0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_done(resp_done), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    mem_arbiter #(.ADDR_W(ADDR_W), .RR(1'b0)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_done(resp_done_b), .resp_err(resp_err_b), .resp_rdata(resp_rdata_b),
        .araddr(araddr_b), .arsize(arsize_b), .arvalid(arvalid_b), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready_b),
        .awaddr(awaddr_b), .awsize(awsize_b), .awvalid(awvalid_b), .awready(awready),
        .wdata(wdata_b), .wstrb(wstrb_b), .wvalid(wvalid_b), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready_b)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_req(input int p, input logic we, input logic [2:0] size,
                             input logic [ADDR_W-1:0] addr, input logic [31:0] wd);
        req_we[p]    = we;
        req_size[p]  = size;
        req_addr[p]  = addr;
        req_wdata[p] = wd;
        req_valid[p] = 1'b1;
        tick();
        req_valid = 2'b00;
    endtask

    // ticks until u0 raises resp_done[p]; a missed bound counts as a failure
    task automatic wait_done(input int p, input string tag);
        bit seen = 1'b0;
        for (int t = 0; t < 30 && !seen; t++) begin
            tick();
            if (resp_done[p]) seen = 1'b1;
        end
        chk_eq({tag, "_timeout"}, {31'd0, seen}, 32'd1);
    endtask

    // both ports pulse together; records done order and timing for u0 and u1
    task automatic run_pair(input string tag, input logic exp_first_rr, input logic exp_first_fp);
        int          n0, n1, t0a, t0b, t1a;
        logic [1:0]  first0, first1, second0, second1;
        n0 = 0; n1 = 0; t0a = 0; t0b = 0; t1a = 0;
        first0 = 2'b00; first1 = 2'b00; second0 = 2'b00; second1 = 2'b00;
        req_we = 2'b00; req_size = '{3'b010, 3'b010};
        req_addr[0] = 22'h000010; req_addr[1] = 22'h000020;
        req_valid = 2'b11;
        tick();
        req_valid = 2'b00;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (resp_done != 2'b00) begin
                if (n0 == 0) begin first0 = resp_done; t0a = t; end
                else if (n0 == 1) begin second0 = resp_done; t0b = t; end
                n0++;
            end
            if (resp_done_b != 2'b00) begin
                if (n1 == 0) begin first1 = resp_done_b; t1a = t; end
                else if (n1 == 1) second1 = resp_done_b;
                n1++;
            end
        end
        chk_eq({tag, "_rr_count"}, n0, 2);
        chk_eq({tag, "_rr_first"}, {30'd0, first0}, exp_first_rr ? 32'd2 : 32'd1);
        chk_eq({tag, "_rr_second"}, {30'd0, second0}, exp_first_rr ? 32'd1 : 32'd2);
        chk_eq({tag, "_rr_gap"}, t0b - t0a, 3);
        chk_eq({tag, "_fp_count"}, n1, 2);
        chk_eq({tag, "_fp_first"}, {30'd0, first1}, exp_first_fp ? 32'd2 : 32'd1);
        chk_eq({tag, "_fp_second"}, {30'd0, second1}, exp_first_fp ? 32'd1 : 32'd2);
        chk_eq({tag, "_fp_first_t"}, t1a, t0a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        rst = 1'b1;
        req_valid = 2'b00; req_we = 2'b00; req_size = '0; req_addr = '0; req_wdata = '0;
        arready = 1'b1; awready = 1'b1; wready = 1'b1;
        rvalid = 1'b0; bvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; bresp = 2'b00;
        tick(); tick();

        // reset state
        chk_eq("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk_eq("rst_awvalid", {31'd0, awvalid}, 32'd0);
        chk_eq("rst_wvalid",  {31'd0, wvalid},  32'd0);
        chk_eq("rst_rready",  {31'd0, rready},  32'd0);
        chk_eq("rst_bready",  {31'd0, bready},  32'd0);
        chk_eq("rst_done",    {30'd0, resp_done}, 32'd0);
        chk_eq("rst_rdata",   resp_rdata, 32'd0);
        chk_eq("rst_wstrb",   {28'd0, wstrb}, 32'd0);
        chk_eq("rst_araddr",  {10'd0, araddr}, 32'd0);
        rst = 1'b0;
        tick();

        // port 0 word load, R beat two cycles after the AR handshake
        pulse_req(0, 1'b0, 3'b010, 22'h000100, 32'h0);
        chk_eq("ld_arvalid_capture", {31'd0, arvalid}, 32'd0);
        tick();
        chk_eq("ld_arvalid", {31'd0, arvalid}, 32'd1);
        chk_eq("ld_araddr",  {10'd0, araddr}, 32'h100);
        chk_eq("ld_arsize",  {29'd0, arsize}, 32'd2);
        chk_eq("ld_rready",  {31'd0, rready}, 32'd1);
        tick();
        chk_eq("ld_arvalid_drop", {31'd0, arvalid}, 32'd0);
        tick();
        rvalid = 1'b1; rdata = 32'hDEADBEEF;
        tick();
        rvalid = 1'b0;
        chk_eq("ld_done",   {30'd0, resp_done}, 32'd1);
        chk_eq("ld_rdata",  resp_rdata, 32'hDEADBEEF);
        chk_eq("ld_err",    {30'd0, resp_err}, 32'd0);
        chk_eq("ld_rready_drop", {31'd0, rready}, 32'd0);
        tick();
        chk_eq("ld_done_pulse", {30'd0, resp_done}, 32'd0);

        // port 1 byte store, W accepted three cycles before AW
        awready = 1'b0; wready = 1'b0;
        pulse_req(1, 1'b1, 3'b000, 22'h000203, 32'h000000A5);
        tick();
        chk_eq("st_awvalid", {31'd0, awvalid}, 32'd1);
        chk_eq("st_wvalid",  {31'd0, wvalid},  32'd1);
        chk_eq("st_bready",  {31'd0, bready},  32'd1);
        chk_eq("st_awaddr",  {10'd0, awaddr}, 32'h203);
        chk_eq("st_awsize",  {29'd0, awsize}, 32'd0);
        chk_eq("st_wstrb",   {28'd0, wstrb}, 32'h8);
        chk_eq("st_wdata",   wdata, 32'hA5A5A5A5);
        wready = 1'b1;
        tick();
        wready = 1'b0;
        chk_eq("st_wvalid_drop", {31'd0, wvalid},  32'd0);
        chk_eq("st_awvalid_hold", {31'd0, awvalid}, 32'd1);
        tick(); tick();
        awready = 1'b1;
        tick();
        chk_eq("st_awvalid_drop", {31'd0, awvalid}, 32'd0);
        chk_eq("st_no_early_done", {30'd0, resp_done}, 32'd0);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        chk_eq("st_done",  {30'd0, resp_done}, 32'd2);
        chk_eq("st_err",   {30'd0, resp_err}, 32'd0);
        chk_eq("st_rdata", resp_rdata, 32'd0);
        chk_eq("st_bready_drop", {31'd0, bready}, 32'd0);
        tick();
        chk_eq("st_done_pulse", {30'd0, resp_done}, 32'd0);
        wready = 1'b1;

        // simultaneous requests; slave answers every AR immediately
        rvalid = 1'b1; rdata = 32'h0;
        for (int k = 0; k < 4; k++)
            run_pair("pair", 1'b0, 1'b0);
        // after a lone port-0 grant, round-robin must favour port 1
        pulse_req(0, 1'b0, 3'b010, 22'h000030, 32'h0);
        wait_done(0, "solo");
        tick();
        run_pair("rrturn", 1'b1, 1'b0);

        // byte load lane extraction and read error
        rdata = 32'h11223344; rresp = 2'b00;
        pulse_req(0, 1'b0, 3'b000, 22'h00000A, 32'h0);
        wait_done(0, "bld");
        chk_eq("bld_rdata", resp_rdata, 32'h00000022);
        chk_eq("bld_err",   {30'd0, resp_err}, 32'd0);
        tick();
        rresp = 2'b10;
        pulse_req(0, 1'b0, 3'b010, 22'h000010, 32'h0);
        wait_done(0, "rerr");
        chk_eq("rerr_err", {30'd0, resp_err}, 32'd1);
        rresp = 2'b00;
        tick();
        chk_eq("rerr_err_clear", {30'd0, resp_err}, 32'd0);

        // reset while waiting for B
        pulse_req(0, 1'b1, 3'b010, 22'h000040, 32'h12345678);
        tick();
        chk_eq("rw_awvalid", {31'd0, awvalid}, 32'd1);
        tick();
        chk_eq("rw_bready_wait", {31'd0, bready}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_eq("rw_bready",  {31'd0, bready},  32'd0);
        chk_eq("rw_awvalid_rst", {31'd0, awvalid}, 32'd0);
        chk_eq("rw_wvalid",  {31'd0, wvalid},  32'd0);
        chk_eq("rw_arvalid", {31'd0, arvalid}, 32'd0);
        chk_eq("rw_rready",  {31'd0, rready},  32'd0);
        dones = 0;
        for (int t = 0; t < 4; t++) begin
            if (resp_done != 2'b00) dones++;
            tick();
        end
        chk_eq("rw_no_done", dones, 0);
        rdata = 32'hCAFEF00D;
        pulse_req(0, 1'b0, 3'b010, 22'h000055, 32'h0);
        wait_done(0, "rw_after");
        chk_eq("rw_after_rdata",  resp_rdata, 32'hCAFEF00D);
        chk_eq("rw_after_araddr", {10'd0, araddr}, 32'h55);

        // request in the done cycle is accepted
        tick();
        rdata = 32'h00000001;
        pulse_req(0, 1'b0, 3'b010, 22'h000100, 32'h0);
        wait_done(0, "dc_first");
        rdata = 32'h00000002;
        pulse_req(0, 1'b0, 3'b010, 22'h000200, 32'h0);
        wait_done(0, "dc_second");
        chk_eq("dc_rdata",  resp_rdata, 32'h2);
        chk_eq("dc_araddr", {10'd0, araddr}, 32'h200);

        // request while pending is ignored
        tick();
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h00000003;
        pulse_req(0, 1'b0, 3'b010, 22'h000300, 32'h0);
        tick();
        pulse_req(0, 1'b0, 3'b010, 22'h0003FC, 32'h0);
        chk_eq("ign_araddr_hold", {10'd0, araddr}, 32'h300);
        arready = 1'b1; rvalid = 1'b1;
        wait_done(0, "ign");
        chk_eq("ign_araddr", {10'd0, araddr}, 32'h300);
        chk_eq("ign_rdata",  resp_rdata, 32'h3);
        dones = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (resp_done != 2'b00) dones++;
        end
        chk_eq("ign_no_second", dones, 0);
        rvalid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
